// File: rtl/snn_input_pkg.sv
// Shared constants and loader state encoding for the SNN input-pixel memory.
// Also used by the SNN core's input address sequencer.
package snn_input_pkg;

  localparam int SNN_NUM_PIXELS       = 784;
  localparam int SNN_PIX_ADDR_W       = 10;
  localparam int SNN_BYTES_PER_SAMPLE = SNN_NUM_PIXELS / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  // Running checksum of the sample bytes (mod 256).
  function automatic logic [7:0] byte_sum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/input_bit_ram.sv
// 1-bit x 2**ADDR_WIDTH pixel RAM: one write port, one registered read port.
// Read-before-write on a same-address collision; contents are never reset.
module input_bit_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic                  rq
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is cleared; the array itself keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq <= 1'b0;
    end else begin
      rq <= mem[raddr];
    end
  end

endmodule

// File: rtl/input_sample_loader.sv
// Writer side of the 1-bit SNN input-pixel memory: unpacks a byte stream, LSB first, into the RAM.
// Define LOADER_CHECKSUM_EN to accept and verify a trailing mod-256 checksum byte.
module input_sample_loader
  import snn_input_pkg::*;
#(
  parameter int ADDR_WIDTH = SNN_PIX_ADDR_W,
  parameter int NUM_PIXELS = SNN_NUM_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIXELS - 1);

  loader_state_e         state_q;
  logic [7:0]            shift_q;
  logic [3:0]            bit_cnt_q;
  logic [ADDR_WIDTH-1:0] pix_cnt_q;
  logic                  accept;
  logic                  ram_we;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // bit_cnt_q counts bits still waiting in the shifter; zero means it is empty.
  assign in_ready = ((state_q == LOAD) && (bit_cnt_q == 4'd0)) || (state_q == CHECK);
  assign accept   = in_valid && in_ready;
  assign ram_we   = (state_q == LOAD) && (bit_cnt_q != 4'd0);
  assign busy     = (state_q == LOAD) || (state_q == CHECK);
  assign done     = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= LOAD;
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (ram_we) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q - 4'd1;
            pix_cnt_q <= pix_cnt_q + ADDR_WIDTH'(1);
            if (pix_cnt_q == LAST_PIX) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= CHECK;
`else
              state_q <= DONE;
`endif
            end
          end else if (accept) begin
            shift_q   <= in_data;
            bit_cnt_q <= 4'd8;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= byte_sum_add(sum_q, in_data);
`endif
          end
        end
        CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) begin
            err_q   <= (in_data != sum_q);
            state_q <= DONE;
          end
`else
          state_q <= DONE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  input_bit_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(pix_cnt_q),
    .wdata(shift_q[0]),
    .raddr(rd_addr),
    .rq   (rd_q)
  );

endmodule

// File: tb/tb_input_sample_loader.sv
// Self-checking bench for input_sample_loader: cycle model of the handshake plus a readback scoreboard.
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum byte.
module tb_input_sample_loader;
  import snn_input_pkg::*;

  localparam int AW     = SNN_PIX_ADDR_W;
  localparam int NPIX   = SNN_NUM_PIXELS;
  localparam int NBYTES = NPIX / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] rd_addr;
  logic          rd_q;

  always #5 clk = ~clk;

  input_sample_loader #(
    .ADDR_WIDTH(AW),
    .NUM_PIXELS(NPIX)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rd_addr (rd_addr),
    .rd_q    (rd_q)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  bit         exp_img [NPIX];
  bit         rd_sb [$];
  logic [7:0] exp_sum;
  bit         aborted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat_byte(input int pat, input int b);
    logic [7:0] v;
    v = '0;
    case (pat)
      0: for (int k = 0; k < 8; k++) v[k] = ((8 * b + k) % 3 == 0);
      1: v = 8'hFF;
      2: v = 8'h00;
      default: v = 8'((b * 37 + 11) % 256);
    endcase
    return v;
  endfunction

  // One sample load. start_at/rst_at >= 0 inject a mid-load start or reset at that byte.
  task automatic run_load(input string name, input int pat, input bit gaps, input int start_at,
                          input int rst_at, input bit rbw, input logic [7:0] sum_err);
    int sent, left, cyc;
    bit acc;
    aborted = 1'b0;
    exp_sum = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq($sformatf("%s:done_clr", name), done, 0);
    check_eq($sformatf("%s:busy_set", name), busy, 1);
    check_eq($sformatf("%s:err_clr", name), err, 0);
    sent = 0; left = 0; cyc = 0;
    while (!(sent == NBYTES && left == 0) && cyc < 4 * NBYTES * 9) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = pat_byte(pat, sent);
      start    = (start_at >= 0 && sent == start_at && left == 3);
      check_eq($sformatf("%s:in_ready@%0d", name, cyc), in_ready, (left == 0 && sent < NBYTES));
      check_eq($sformatf("%s:busy@%0d", name, cyc), busy, 1);
      check_eq($sformatf("%s:done@%0d", name, cyc), done, 0);
      acc = in_valid && (left == 0) && (sent < NBYTES);
      if (rst_at >= 0 && sent == rst_at && left == 4) begin
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        #1;
        check_eq($sformatf("%s:rst_busy", name), busy, 0);
        check_eq($sformatf("%s:rst_done", name), done, 0);
        check_eq($sformatf("%s:rst_ready", name), in_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (left > 0) left--;
      else if (acc) begin
        for (int k = 0; k < 8; k++) exp_img[8 * sent + k] = in_data[k];
        exp_sum = exp_sum + in_data;
        left = 8;
        sent++;
      end
      if (rbw && cyc == 2) check_eq($sformatf("%s:rbw_old", name), rd_q, 1);
      if (rbw && cyc == 3) check_eq($sformatf("%s:rbw_new", name), rd_q, 0);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (aborted) begin
      $display("%s: aborted by reset at byte %0d", name, sent);
      return;
    end
    check_eq($sformatf("%s:bytes", name), sent, NBYTES);
    if (!gaps) check_eq($sformatf("%s:latency", name), cyc, NBYTES * 9);
`ifdef LOADER_CHECKSUM_EN
    check_eq($sformatf("%s:chk_ready", name), in_ready, 1);
    check_eq($sformatf("%s:chk_done", name), done, 0);
    in_valid = 1'b1;
    in_data  = exp_sum + sum_err;
    @(posedge clk); #1 in_valid = 1'b0;
    check_eq($sformatf("%s:err", name), err, (sum_err != 8'd0));
`else
    check_eq($sformatf("%s:err", name), err, 0);
`endif
    check_eq($sformatf("%s:done_end", name), done, 1);
    check_eq($sformatf("%s:busy_end", name), busy, 0);
    check_eq($sformatf("%s:ready_end", name), in_ready, 0);
    repeat (3) @(posedge clk);
    #1 check_eq($sformatf("%s:done_hold", name), done, 1);
    $display("%s: loaded %0d bytes in %0d cycles", name, sent, cyc);
  endtask

  task automatic readback(input string name);
    int fails0;
    fails0 = n_checks - n_pass;
    for (int i = 0; i <= NPIX; i++) begin
      @(posedge clk); #1;
      if (i < NPIX) begin
        rd_addr = AW'(i);
        rd_sb.push_back(exp_img[i]);
      end
      @(negedge clk);
      if (i > 0) check_eq($sformatf("%s:rd_pix[%0d]", name, i - 1), rd_q, rd_sb.pop_front());
    end
    rd_addr = '0;
    $display("%s: readback of %0d pixels, %0d wrong", name, NPIX, (n_checks - n_pass) - fails0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset:in_ready", in_ready, 0);
    check_eq("reset:busy", busy, 0);
    check_eq("reset:done", done, 0);
    check_eq("reset:err", err, 0);
    check_eq("reset:rd_q", rd_q, 0);
    rst_n = 1'b1;

    run_load("t1_pattern", 0, 1'b0, -1, -1, 1'b0, 8'd0);
    readback("t1_pattern");
    run_load("t2_gaps", 3, 1'b1, -1, -1, 1'b0, 8'd0);
    readback("t2_gaps");
    run_load("t3_midstart", 0, 1'b0, 40, -1, 1'b0, 8'd0);
    readback("t3_midstart");
    run_load("t4_abort", 3, 1'b0, -1, 50, 1'b0, 8'd0);
    run_load("t4_reload", 0, 1'b0, -1, -1, 1'b0, 8'd0);
    readback("t4_reload");
    run_load("t5_ones", 1, 1'b0, -1, -1, 1'b0, 8'd0);
    run_load("t5_zeros", 2, 1'b0, -1, -1, 1'b1, 8'd0);
    readback("t5_zeros");
`ifdef LOADER_CHECKSUM_EN
    run_load("t6_badsum", 3, 1'b0, -1, -1, 1'b0, 8'd1);
    run_load("t6_goodsum", 3, 1'b0, -1, -1, 1'b0, 8'd0);
    readback("t6_goodsum");
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
